// File: rtl/exins_pkg.sv
// Shared types and helpers for the external-instruction loader.
package exins_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE,
        ERR
    } loader_state_t;

    localparam logic [31:0] WORD_BYTES = 32'd4;

    // Byte address of word `words` in an image starting at `base`; wraps modulo 2^32.
    function automatic logic [31:0] addr_inc(input logic [31:0] base, input logic [31:0] words);
        return base + (words * WORD_BYTES);
    endfunction

endpackage

// File: rtl/exins_fifo.sv
// Response buffer between the exIns source and the imem write port.
module exins_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rp_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wp_q] <= wdata_i;
                wp_q        <= wp_q + PW'(1);
            end
            if (do_pop) rp_q <= rp_q + PW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/exins_loader.sv
// Streams a program image over exIns into imem while holding the core.
// Optional trailer checksum: define EXINS_CHECKSUM_EN.
module exins_loader
    import exins_pkg::*;
#(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned IMEM_DEPTH      = 256,
    parameter int unsigned ADDR_W          = $clog2(IMEM_DEPTH),
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [31:0]       base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              exIns_ren,
    output logic [31:0]       exIns_addr,
    input  logic              exIns_valid,
    input  logic [XLEN-1:0]   exIns_in,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [XLEN-1:0]   imem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
`ifdef EXINS_CHECKSUM_EN
    output logic              csum_ok,
`endif
    output logic              err
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned OW    = $clog2(MAX_OUTSTANDING) + 1;

    loader_state_t    state_q, state_d;
    logic [31:0]      base_q, base_d, addr_q, addr_d;
    logic [CNT_W-1:0] count_q, count_d, issued_q, issued_d, written_q, written_d, total;
    logic [OW-1:0]    outst_q, outst_d, fcnt, occ_next;
    logic             ren_q, ren_d;
    logic             push, pop, full, empty, active, stray, accept, issue, to_err, trailer, trl_ok;
    logic [XLEN-1:0]  rdata;

`ifdef EXINS_CHECKSUM_EN
    logic [CNT_W-1:0] recv_q, recv_d;
    logic [XLEN-1:0]  sum_q, sum_d;
    logic             trl_q, trl_d, csum_q, csum_d;
    assign total   = count_q + CNT_W'(1);
    assign csum_ok = csum_q;
`else
    assign total = count_q;
`endif

    exins_fifo #(
        .W     (XLEN),
        .DEPTH (MAX_OUTSTANDING),
        .CW    (OW)
    ) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .push_i  (push),
        .wdata_i (exIns_in),
        .pop_i   (pop),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fcnt)
    );

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        count_d   = count_q;
        issued_d  = issued_q;
        written_d = written_q;
        outst_d   = outst_q;
        ren_d     = 1'b0;
        addr_d    = addr_q;
        push      = 1'b0;
        pop       = 1'b0;
        accept    = 1'b0;
        issue     = 1'b0;
        trailer   = 1'b0;
        occ_next  = fcnt;
`ifdef EXINS_CHECKSUM_EN
        recv_d = recv_q;
        sum_d  = sum_q;
        trl_d  = trl_q;
        csum_d = csum_q;
`endif
        active = (state_q == LOAD) || (state_q == DRAIN);
        stray  = exIns_valid && (outst_q == '0);
        to_err = stray;

        if (active) begin
            accept = exIns_valid && !stray;
            pop    = !empty;
            // Credit counts both in-flight requests and buffered words, so a push never finds the buffer full.
            issue  = (state_q == LOAD) && (issued_q < total) &&
                     (((OW+1)'(outst_q) + (OW+1)'(fcnt)) < (OW+1)'(MAX_OUTSTANDING));
`ifdef EXINS_CHECKSUM_EN
            trailer = accept && (recv_q == count_q);
            if (accept) recv_d = recv_q + CNT_W'(1);
            if (trailer) begin
                if (exIns_in == sum_q) trl_d = 1'b1;
                else                   to_err = 1'b1;
            end else if (accept) begin
                sum_d = sum_q + exIns_in;
            end
`endif
            push      = accept && !trailer && !full;
            written_d = written_q + CNT_W'(pop);
            outst_d   = outst_q + OW'(issue) - OW'(accept);
            occ_next  = fcnt + OW'(push) - OW'(pop);
        end

`ifdef EXINS_CHECKSUM_EN
        trl_ok = trl_d;
`else
        trl_ok = 1'b1;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (stray) begin
                    state_d = ERR;
                end else if (start) begin
                    if (word_count > CNT_W'(IMEM_DEPTH)) begin
                        state_d = ERR;
                    end else begin
                        state_d   = LOAD;
                        base_d    = base_addr;
                        count_d   = word_count;
                        issued_d  = '0;
                        written_d = '0;
`ifdef EXINS_CHECKSUM_EN
                        recv_d = '0;
                        sum_d  = '0;
                        trl_d  = 1'b0;
                        csum_d = 1'b0;
`endif
                    end
                end
            end
            LOAD, DRAIN: begin
                // Completion looks at next-cycle values so the hold drops right after the final write.
                if (to_err) begin
                    state_d = ERR;
                end else if ((written_d == count_q) && (occ_next == '0) && (outst_d == '0) && trl_ok) begin
                    state_d = DONE;
`ifdef EXINS_CHECKSUM_EN
                    csum_d = 1'b1;
`endif
                end else if ((state_q == LOAD) && (issued_q == total)) begin
                    state_d = DRAIN;
                end
            end
            default: ;
        endcase

        if (issue && !to_err) begin
            ren_d    = 1'b1;
            addr_d   = addr_inc(base_q, 32'(issued_q));
            issued_d = issued_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            count_q   <= '0;
            issued_q  <= '0;
            written_q <= '0;
            outst_q   <= '0;
            ren_q     <= 1'b0;
            addr_q    <= '0;
`ifdef EXINS_CHECKSUM_EN
            recv_q <= '0;
            sum_q  <= '0;
            trl_q  <= 1'b0;
            csum_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            count_q   <= count_d;
            issued_q  <= issued_d;
            written_q <= written_d;
            outst_q   <= outst_d;
            ren_q     <= ren_d;
            addr_q    <= addr_d;
`ifdef EXINS_CHECKSUM_EN
            recv_q <= recv_d;
            sum_q  <= sum_d;
            trl_q  <= trl_d;
            csum_q <= csum_d;
`endif
        end
    end

    assign exIns_ren  = ren_q;
    assign exIns_addr = addr_q;
    assign imem_we    = pop;
    assign imem_addr  = pop ? written_q[ADDR_W-1:0] : '0;
    assign imem_wdata = pop ? rdata : '0;
    assign core_hold  = (state_q != DONE);
    assign busy       = active;
    assign done       = (state_q == DONE);
    assign err        = (state_q == ERR);

endmodule

// File: tb/tb_exins_loader.sv
// Directed bench for exins_loader with an in-order, fixed-latency exIns source model.
module tb_exins_loader;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;
    localparam int unsigned MAXO  = 4;
`ifdef EXINS_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic            clk = 1'b0;
    logic            nrst = 1'b0;
    logic            start = 1'b0;
    logic [31:0]     base_addr = '0;
    logic [AW:0]     word_count = '0;
    logic            exIns_ren;
    logic [31:0]     exIns_addr;
    logic            exIns_valid = 1'b0;
    logic [XLEN-1:0] exIns_in = '0;
    logic            imem_we;
    logic [AW-1:0]   imem_addr;
    logic [XLEN-1:0] imem_wdata;
    logic            core_hold, busy, done, err;
`ifdef EXINS_CHECKSUM_EN
    logic            csum_ok;
`endif

    exins_loader #(
        .XLEN            (XLEN),
        .IMEM_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .start       (start),
        .base_addr   (base_addr),
        .word_count  (word_count),
        .exIns_ren   (exIns_ren),
        .exIns_addr  (exIns_addr),
        .exIns_valid (exIns_valid),
        .exIns_in    (exIns_in),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .core_hold   (core_hold),
        .busy        (busy),
        .done        (done),
`ifdef EXINS_CHECKSUM_EN
        .csum_ok     (csum_ok),
`endif
        .err         (err)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          lat = 1;
    int          last_wr = 0;
    int          fall = 0;
    int          max_pend = 0;
    bit          prev_hold = 1'b1;
    bit          stray = 1'b0;
    logic [31:0] cur_base = '0;
    logic [31:0] tab [512];
    logic [31:0] req_q[$];
    logic [31:0] pend_a[$];
    int          pend_d[$];
    logic [31:0] wra[$];
    logic [31:0] wrd[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: observe DUT outputs at the falling edge, then drive this cycle's response.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (exIns_ren) begin
            req_q.push_back(exIns_addr);
            pend_a.push_back(exIns_addr);
            pend_d.push_back(cyc + lat);
        end
        if (pend_a.size() > max_pend) max_pend = pend_a.size();
        if (imem_we) begin
            wra.push_back(32'(imem_addr));
            wrd.push_back(imem_wdata);
            last_wr = cyc;
        end
        if (prev_hold && !core_hold) fall = cyc;
        prev_hold   = core_hold;
        exIns_valid = 1'b0;
        exIns_in    = '0;
        if (!nrst) begin
            pend_a.delete();
            pend_d.delete();
        end else if (stray) begin
            exIns_valid = 1'b1;
            exIns_in    = 32'hDEAD_BEEF;
            stray       = 1'b0;
        end else if (pend_d.size() > 0 && pend_d[0] <= cyc) begin
            exIns_valid = 1'b1;
            exIns_in    = tab[9'((pend_a[0] - cur_base) >> 2)];
            void'(pend_a.pop_front());
            void'(pend_d.pop_front());
        end
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        #1;
        chk("rst_ren",   32'(exIns_ren),  0);
        chk("rst_addr",  exIns_addr,      0);
        chk("rst_we",    32'(imem_we),    0);
        chk("rst_iaddr", 32'(imem_addr),  0);
        chk("rst_wdata", imem_wdata,      0);
        chk("rst_hold",  32'(core_hold),  1);
        chk("rst_busy",  32'(busy),       0);
        chk("rst_done",  32'(done),       0);
        chk("rst_err",   32'(err),        0);
        tick();
        tick();
        nrst = 1'b1;
        tick();
    endtask

    task automatic start_load(input logic [31:0] b, input int cnt, input int l);
        req_q.delete();
        wra.delete();
        wrd.delete();
        max_pend = 0;
        lat      = l;
        cur_base = b;
        fall     = 0;
        last_wr  = 0;
`ifdef EXINS_CHECKSUM_EN
        begin
            logic [31:0] s;
            s = '0;
            for (int i = 0; i < cnt; i++) s = s + tab[i];
            if (cnt < 512) tab[cnt] = s;
        end
`endif
        base_addr  = b;
        word_count = (AW+1)'(cnt);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = 0;
        while (!(done || err) && n < budget) begin
            tick();
            n++;
        end
        chk("end_reached", 32'(done | err), 1);
    endtask

    task automatic check_writes(input int cnt);
        chk("wr_cnt", 32'(wra.size()), 32'(cnt));
        for (int i = 0; i < wra.size(); i++) begin
            chk("wr_addr", wra[i], 32'(i));
            chk("wr_data", wrd[i], tab[i]);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 512; i++) tab[i] = 32'hA500_0000 + 32'(i * 3);
        do_reset();

        // Basic load, latency 1
        start_load(32'h0, 8, 1);
        wait_end(200);
        chk("t1_done", 32'(done), 1);
        chk("t1_err", 32'(err), 0);
        chk("t1_hold", 32'(core_hold), 0);
        check_writes(8);
        chk("t1_hold_fall", 32'(fall - last_wr), 1);
        chk("t1_reqs", 32'(req_q.size()), 32'(8 + EXTRA));

        // Long latency, credit limit, restart from DONE
        start_load(32'h100, 16, 5);
        chk("t2_hold", 32'(core_hold), 1);
        chk("t2_done", 32'(done), 0);
        chk("t2_busy", 32'(busy), 1);
        wait_end(400);
        chk("t2_done_end", 32'(done), 1);
        check_writes(16);
        for (int i = 0; i < 16; i++) chk("t2_req_addr", req_q[i], 32'h100 + 32'(4 * i));
        chk("t2_max_pend_le4", 32'(max_pend <= 4), 1);
        chk("t2_reqs", 32'(req_q.size()), 32'(16 + EXTRA));

`ifndef EXINS_CHECKSUM_EN
        // Empty image
        start_load(32'h40, 0, 1);
        chk("t3_done_c1", 32'(done), 0);
        tick();
        chk("t3_done_c2", 32'(done), 1);
        chk("t3_reqs", 32'(req_q.size()), 0);
        chk("t3_writes", 32'(wra.size()), 0);
`endif

        // Oversized image
        start_load(32'h0, DEPTH + 1, 1);
        chk("t3_big_err", 32'(err), 1);
        chk("t3_big_hold", 32'(core_hold), 1);
        repeat (3) tick();
        chk("t3_big_err2", 32'(err), 1);
        chk("t3_big_hold2", 32'(core_hold), 1);
        chk("t3_big_reqs", 32'(req_q.size()), 0);

        // Stray response in IDLE, then start is ignored
        do_reset();
        stray = 1'b1;
        tick();
        tick();
        chk("t4_stray_err", 32'(err), 1);
        start_load(32'h0, 4, 1);
        repeat (5) tick();
        chk("t4_err_sticky", 32'(err), 1);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_reqs", 32'(req_q.size()), 0);
        chk("t4_writes", 32'(wra.size()), 0);

        // Reset mid-load, then clean reload
        do_reset();
        start_load(32'h200, 10, 2);
        n = 0;
        while (wra.size() < 3 && n < 200) begin
            tick();
            n++;
        end
        chk("t5_three_written", 32'(wra.size()), 3);
        do_reset();
        start_load(32'h200, 10, 2);
        wait_end(300);
        chk("t5_done", 32'(done), 1);
        chk("t5_err", 32'(err), 0);
        check_writes(10);

`ifdef EXINS_CHECKSUM_EN
        // Trailer checksum: match then mismatch
        for (int i = 0; i < 4; i++) tab[i] = 32'(i + 1);
        start_load(32'h400, 4, 3);
        tab[4] = 32'd10;
        wait_end(200);
        chk("t6_done", 32'(done), 1);
        chk("t6_csum_ok", 32'(csum_ok), 1);
        check_writes(4);
        start_load(32'h400, 4, 3);
        tab[4] = 32'd11;
        wait_end(200);
        chk("t6_bad_err", 32'(err), 1);
        chk("t6_bad_csum", 32'(csum_ok), 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/exins_loader.md
Name: exins_loader

Overview:
Parametrised external-instruction loader. It streams a program image from an external source over the exIns request/response interface into instruction memory. It holds the core in reset-equivalent hold until the image is committed. It sits between the core's exIns_* pins and the imem write port, and is the synthesizable successor to testbench-side hex preloading: configurable width, depth and number of outstanding requests, plus error detection.

Parameters:
XLEN, 32, instruction word width in bits
IMEM_DEPTH, 256, instruction memory depth in words
ADDR_W, $clog2(IMEM_DEPTH), imem word-address width
MAX_OUTSTANDING, 4, maximum in-flight exIns requests; also the response buffer depth (power of two, >=2)

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a load
base_addr  in  32  external byte address of word 0 (word aligned)
word_count  in  ADDR_W+1  number of words to load
exIns_ren  out  1  request strobe; one request per high cycle
exIns_addr  out  32  request byte address
exIns_valid  in  1  response valid; responses return in request order, latency >=1 cycle
exIns_in  in  XLEN  response data
imem_we  out  1  imem write enable
imem_addr  out  ADDR_W  imem word address
imem_wdata  out  XLEN  imem write data
core_hold  out  1  holds the core while high
busy  out  1  load in progress
done  out  1  sticky; image committed
err  out  1  sticky; load aborted

Behaviour:
- Reset (async, nrst=0): FSM=IDLE; exIns_ren=0, exIns_addr=0, imem_we=0, imem_addr=0, imem_wdata=0, core_hold=1, busy=0, done=0, err=0. Counters and buffer are cleared. Reset mid-load abandons the load. Responses arriving after reset deassertion with nothing outstanding raise err.
- FSM states: IDLE, LOAD, DRAIN, DONE, ERR.
- IDLE: on start, latch base_addr and word_count, clear issued/received/written counters, go to LOAD.
  - word_count==0 goes to DONE next cycle.
  - word_count>IMEM_DEPTH goes to ERR.
- LOAD:
  - exIns_ren=1 when issued<word_count and (outstanding + buffer occupancy) < MAX_OUTSTANDING.
  - exIns_addr = base + 4*issued, registered with ren.
  - Go to DRAIN when issued==word_count.
- Responses: each exIns_valid cycle pushes exIns_in into the buffer. The credit rule guarantees the buffer is never full on push.
- Commit: when the buffer is non-empty, pop one word per cycle. Drive imem_we=1, imem_addr=written, imem_wdata=word; written increments. Push-to-write latency is 1 cycle. Simultaneous push and pop in the same cycle keeps occupancy unchanged.
- DRAIN: stop issuing. Go to DONE when written==word_count and the buffer is empty.
- DONE: done=1, core_hold=0, busy=0. A new start re-enters LOAD with core_hold=1 and done cleared.
- ERR: err=1, core_hold=1, ren=0, we=0. Exit only via reset.
- Error triggers:
  - exIns_valid with zero outstanding requests.
  - word_count>IMEM_DEPTH.
- start while busy (LOAD/DRAIN) is ignored.
- busy=1 in LOAD and DRAIN.
- core_hold=1 in every state except DONE, and also in IDLE after reset.
- Address arithmetic is 32-bit and wraps modulo 2^32. imem_addr never exceeds word_count-1.

Optional Feature:
EXINS_CHECKSUM_EN
- Defined: after word_count data words, the loader requests one extra trailer word at base+4*word_count.
  - The trailer is not written to imem.
  - It is compared against the XLEN-bit wrap-around sum of all data words.
  - Mismatch goes to ERR; match goes to DONE.
  - Adds output csum_ok (1 bit, reset 0), set together with done.
- Undefined: no trailer request, no csum_ok port, no adder logic.

Decomposition:
- Package exins_pkg:
  - state enum loader_state_t {IDLE, LOAD, DRAIN, DONE, ERR};
  - localparam WORD_BYTES=4;
  - an address-increment function.
- One natural sub-module: exins_fifo, a synchronous FIFO (XLEN x MAX_OUTSTANDING) with push, pop, full, empty and count, async active-low reset on clk/nrst.
- The loader owns the FSM, counters and credit logic.

Test Plan:
- Reset then start with base_addr=0x0, word_count=8, source latency 1 → 8 imem writes at addr 0..7 with matching data; done=1, core_hold falls one cycle after the last write; err=0.
- Source latency 5, MAX_OUTSTANDING=4, word_count=16 → never more than 4 requests unanswered; exIns_addr sequence 0x100..0x13C for base 0x100; all 16 words written in order.
- word_count=0 → done=1 two cycles after start, no exIns_ren, no imem_we; word_count=IMEM_DEPTH+1 → err=1, core_hold stays 1.
- exIns_valid pulsed in IDLE after reset → err=1 next cycle; subsequent start ignored.
- nrst asserted after 3 of 10 words are written, then a fresh start with word_count=10 → all outputs at reset values during reset; clean reload of 10 words, done=1.
- EXINS_CHECKSUM_EN: 4 words 1,2,3,4 with trailer 10 → done=1, csum_ok=1, 4 imem writes; trailer 11 → err=1, csum_ok=0.
